parking_exit_gate: RTL
======================

// Module: parking_exit_gate
// PURPOSE
//  Exit-lane controller for the car park, the outbound counterpart of the entrance lane.
//  Tracks lot occupancy from entry pulses and completed exits.
//  Collects the exit fee through a coin interface, opens the gate, and returns change.
//  Drives the exit LEDs and shows free spaces or a status code on two 7-seg digits.
// PARAMETERS
//  CAPACITY     15  max cars in lot, 1..99; occupancy width OW = $clog2(CAPACITY+1)
//  FEE          3   exit fee in coin units, 1..15
//  PAY_TIMEOUT  8   cycles without a coin in WAIT_PAY before ERROR, >=2
// PORTS
//  clk                  in   1   system clock, all logic on posedge
//  reset_n              in   1   async active-low reset
//  car_entered          in   1   1-cycle pulse from entrance lane: one car passed its gate
//  sensor_exit_approach in   1   car present at exit payment point (level)
//  sensor_exit_clear    in   1   car has passed the exit gate (level)
//  coin_valid           in   1   1-cycle strobe, coin_value valid
//  coin_value           in   2   coin worth 0..3 units
//  occupancy            out  OW  cars currently in lot
//  full                 out  1   occupancy == CAPACITY
//  gate_open            out  1   exit barrier open
//  change_due           out  4   credit - FEE while PAID, else 0
//  GREEN_LED, RED_LED   out  1   lane lights
//  HEX_1, HEX_2         out  7   active-low 7-seg, tens/left and ones/right
// BEHAVIOUR
//  Reset (async):
//   - state=IDLE; occupancy=0, credit=0, timer=0, blink=0.
//   - Outputs: gate_open=0, change_due=0, LEDs=0; HEX shows free spaces.
//  Outputs are Moore decodes of registered state and counters; visible the cycle the register updates.
//  Occupancy, updated each clk:
//   - inc = car_entered && !full; dec = exit completion (PAID && sensor_exit_clear).
//   - inc&&dec -> unchanged; inc only -> +1; dec only -> -1.
//   - car_entered while full is dropped (saturate, no wrap).
//  credit: 4-bit, saturates at 15; cleared on entering WAIT_PAY from IDLE and on leaving PAID.
//  FSM:
//   IDLE:
//    - approach && occupancy>0 -> WAIT_PAY, credit=0, timer=0.
//    - approach with occupancy==0 is ignored.
//   WAIT_PAY:
//    - !approach -> IDLE; credit discarded, no change paid.
//    - Else, coin_valid: credit += coin_value and timer=0; if new credit >= FEE -> PAID next cycle.
//    - Else timer++; timer == PAY_TIMEOUT-1 -> ERROR.
//   PAID:
//    - gate_open=1, change_due = credit-FEE.
//    - sensor_exit_clear -> IDLE, occupancy-1 same edge, credit=0.
//    - Approach dropping alone does not close the gate.
//   ERROR:
//    - !approach -> IDLE.
//    - coin_valid -> credit += value; if credit >= FEE -> PAID, else WAIT_PAY with timer=0.
//   Precedence: !approach is checked before coin_valid in WAIT_PAY and ERROR.
//  LEDs:
//   - IDLE: both 0. WAIT_PAY: RED=1.
//   - PAID: GREEN=1. ERROR: RED=blink.
//   - blink toggles every clk while in ERROR and is 0 otherwise.
//  HEX:
//   - IDLE: decimal tens/ones of CAPACITY-occupancy; tens digit blank (7'h7F) when <10.
//   - WAIT_PAY: 'P' 7'b0001100 / 'A' 7'b0001000.
//   - PAID: '6' 7'b0000010 / '0' 7'b1000000.
//   - ERROR: 'E' 7'b0000110 on both digits.
//   - Digits 0-9 use the standard active-low segment table.
//  Reset mid-operation: returns to reset values immediately, gate closes, occupancy lost to 0.
// TESTING
//  - 16 car_entered pulses with CAPACITY=15 -> occupancy=15, full=1 after the 15th; 16th ignored; HEX_2 shows '0'.
//  - occupancy=2, approach, coins 2 then 2 -> PAID, gate_open=1, change_due=1; clear -> IDLE, occupancy=1.
//  - Approach, no coins for 7 cycles -> ERROR, RED toggles; coin 3 -> PAID, change_due=0.
//  - Approach, coin 1, approach drops -> IDLE, credit=0, occupancy unchanged, gate never opens.
//  - PAID && sensor_exit_clear with car_entered on the same cycle -> occupancy unchanged.
//  - Approach with occupancy=0 -> stays IDLE. Reset_n low during PAID -> gate_open=0 async, occupancy=0.

Source files
------------

// File: rtl/parking_exit_gate.sv
// parking_exit_gate: exit-lane controller for the car park.
//   Tracks lot occupancy from entrance pulses and completed exits. Collects the
//   exit fee through a coin interface, opens the barrier and reports change due.
//   Drives the lane LEDs and shows free spaces or a status code on two 7-seg digits.
// Ports:
//   clk, reset_n          clock (posedge), asynchronous active-low reset
//   car_entered           1-cycle pulse: a car passed the entrance gate
//   sensor_exit_approach  car waiting at the payment point (level)
//   sensor_exit_clear     car has passed the exit barrier (level)
//   coin_valid/coin_value coin strobe and its worth (0..3 units)
//   occupancy, full       cars in the lot, lot-full flag
//   gate_open, change_due barrier control, credit minus fee while paid
//   GREEN_LED, RED_LED    lane lights
//   HEX_1, HEX_2          active-low 7-seg, tens/left and ones/right
module parking_exit_gate #(
    parameter int unsigned CAPACITY    = 15,
    parameter int unsigned FEE         = 3,
    parameter int unsigned PAY_TIMEOUT = 8,
    localparam int unsigned OW         = $clog2(CAPACITY + 1),
    localparam int unsigned TW         = $clog2(PAY_TIMEOUT)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          car_entered,
    input  logic          sensor_exit_approach,
    input  logic          sensor_exit_clear,
    input  logic          coin_valid,
    input  logic [1:0]    coin_value,
    output logic [OW-1:0] occupancy,
    output logic          full,
    output logic          gate_open,
    output logic [3:0]    change_due,
    output logic          GREEN_LED,
    output logic          RED_LED,
    output logic [6:0]    HEX_1,
    output logic [6:0]    HEX_2
);

    typedef enum logic [1:0] {StIdle, StWaitPay, StPaid, StError} state_e;

    localparam logic [6:0] SegBlank = 7'h7F;
    localparam logic [6:0] SegP     = 7'b0001100;
    localparam logic [6:0] SegA     = 7'b0001000;
    localparam logic [6:0] Seg6     = 7'b0000010;
    localparam logic [6:0] Seg0     = 7'b1000000;
    localparam logic [6:0] SegE     = 7'b0000110;

    state_e          state_q, state_d;
    logic [OW-1:0]   occ_q, occ_d;
    logic [3:0]      credit_q, credit_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            blink_q, blink_d;

    logic            inc, dec;
    logic [4:0]      credit_sum;
    logic [3:0]      credit_add;
    logic [TW-1:0]   timer_inc;
    logic [6:0]      free_spaces, free_tens, free_ones;

    function automatic logic [6:0] seg7(input logic [6:0] d);
        unique case (d)
            7'd0:    seg7 = 7'b1000000;
            7'd1:    seg7 = 7'b1111001;
            7'd2:    seg7 = 7'b0100100;
            7'd3:    seg7 = 7'b0110000;
            7'd4:    seg7 = 7'b0011001;
            7'd5:    seg7 = 7'b0010010;
            7'd6:    seg7 = 7'b0000010;
            7'd7:    seg7 = 7'b1111000;
            7'd8:    seg7 = 7'b0000000;
            7'd9:    seg7 = 7'b0010000;
            default: seg7 = SegBlank;
        endcase
    endfunction

    assign full       = (occ_q == OW'(CAPACITY));
    assign inc        = car_entered && !full;
    // Guard against underflow even though PAID is only reachable with cars in the lot.
    assign dec        = (state_q == StPaid) && sensor_exit_clear && (occ_q != '0);
    // Credit saturates at 15 rather than wrapping.
    assign credit_sum = {1'b0, credit_q} + {3'b000, coin_value};
    assign credit_add = credit_sum[4] ? 4'hF : credit_sum[3:0];
    assign timer_inc  = timer_q + TW'(1);

    always_comb begin
        occ_d = occ_q;
        unique case ({inc, dec})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        timer_d  = timer_q;
        unique case (state_q)
            StIdle: begin
                if (sensor_exit_approach && (occ_q != '0)) begin
                    state_d  = StWaitPay;
                    credit_d = '0;
                    timer_d  = '0;
                end
            end
            StWaitPay: begin
                if (!sensor_exit_approach) begin
                    state_d  = StIdle;
                    credit_d = '0;
                end else if (coin_valid) begin
                    credit_d = credit_add;
                    timer_d  = '0;
                    if (credit_add >= 4'(FEE)) state_d = StPaid;
                end else begin
                    timer_d = timer_inc;
                    if (timer_inc == TW'(PAY_TIMEOUT - 1)) state_d = StError;
                end
            end
            StPaid: begin
                if (sensor_exit_clear) begin
                    state_d  = StIdle;
                    credit_d = '0;
                end
            end
            StError: begin
                if (!sensor_exit_approach) begin
                    state_d  = StIdle;
                    credit_d = '0;
                end else if (coin_valid) begin
                    credit_d = credit_add;
                    timer_d  = '0;
                    state_d  = (credit_add >= 4'(FEE)) ? StPaid : StWaitPay;
                end
            end
            default: state_d = StIdle;
        endcase
        // Blink only runs while staying in ERROR so each ERROR visit starts dark.
        blink_d = (state_q == StError && state_d == StError) ? ~blink_q : 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            occ_q    <= '0;
            credit_q <= '0;
            timer_q  <= '0;
            blink_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            occ_q    <= occ_d;
            credit_q <= credit_d;
            timer_q  <= timer_d;
            blink_q  <= blink_d;
        end
    end

    assign free_spaces = 7'(CAPACITY) - 7'(occ_q);
    assign free_tens   = free_spaces / 7'd10;
    assign free_ones   = free_spaces % 7'd10;
    assign occupancy   = occ_q;

    always_comb begin
        gate_open  = 1'b0;
        change_due = 4'd0;
        GREEN_LED  = 1'b0;
        RED_LED    = 1'b0;
        HEX_1      = (free_spaces < 7'd10) ? SegBlank : seg7(free_tens);
        HEX_2      = seg7(free_ones);
        unique case (state_q)
            StWaitPay: begin
                RED_LED = 1'b1;
                HEX_1   = SegP;
                HEX_2   = SegA;
            end
            StPaid: begin
                gate_open  = 1'b1;
                change_due = credit_q - 4'(FEE);
                GREEN_LED  = 1'b1;
                HEX_1      = Seg6;
                HEX_2      = Seg0;
            end
            StError: begin
                RED_LED = blink_q;
                HEX_1   = SegE;
                HEX_2   = SegE;
            end
            default: ;
        endcase
    end

endmodule
